// File: rtl/mmio_pkg.sv
// Shared types and default memory map for the MMIO bus controller.
// Region order: 0=RAM, 1=PS2, 2=VRAM, 3=misc peripheral window.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int          DEF_NUM_REGIONS = 4;
  localparam logic [31:0] DEF_REGION_BASE [DEF_NUM_REGIONS] =
    '{32'h0000_0000, 32'h0000_4000, 32'h0000_8000, 32'h0001_0000};
  localparam int          DEF_REGION_LOG2 [DEF_NUM_REGIONS] = '{14, 2, 15, 4};
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  // Index width that stays legal for a single-region map.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_region_match.sv
// Combinational address decoder: compares an address against every window and
// returns the lowest-index hit as one-hot, as an index, and as a window offset.
module mmio_region_match
  import mmio_pkg::*;
#(
  parameter int                NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] REGION_BASE [NUM_REGIONS] = DEF_REGION_BASE,
  parameter int                REGION_LOG2 [NUM_REGIONS] = DEF_REGION_LOG2,
  localparam int               IW          = idx_w(NUM_REGIONS)
) (
  input  logic [ADDR_W-1:0]      i_addr,
  output logic [NUM_REGIONS-1:0] o_hit,
  output logic                   o_found,
  output logic [IW-1:0]          o_idx,
  output logic [ADDR_W-1:0]      o_offset
);

  logic [NUM_REGIONS-1:0] w_raw_hit;

  generate
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_cmp
      assign w_raw_hit[gi] =
        (i_addr >> REGION_LOG2[gi]) == (REGION_BASE[gi] >> REGION_LOG2[gi]);
    end
  endgenerate

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    o_hit    = '0;
    o_found  = 1'b0;
    o_idx    = '0;
    o_offset = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (w_raw_hit[i]) begin
        o_hit    = '0;
        o_hit[i] = 1'b1;
        o_found  = 1'b1;
        o_idx    = IW'(i);
        o_offset = i_addr - REGION_BASE[i];
      end
    end
  end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// Sequential memory-map controller: decodes a core request onto one of
// NUM_REGIONS slaves, waits for ready with a timeout, and latches faults.
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int                NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] REGION_BASE [NUM_REGIONS] = DEF_REGION_BASE,
  parameter int                REGION_LOG2 [NUM_REGIONS] = DEF_REGION_LOG2,
  parameter int                TIMEOUT     = 16,
  parameter logic [DATA_W-1:0] ERR_DATA    = DEF_ERR_DATA
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  output logic                          cpu_busy,
  output logic                          cpu_done,
  output logic                          cpu_err,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic [NUM_REGIONS-1:0]        slv_sel,
  output logic                          slv_we,
  output logic [ADDR_W-1:0]             slv_addr,
  output logic [DATA_W-1:0]             slv_wdata,
  input  logic [NUM_REGIONS*DATA_W-1:0] slv_rdata,
  input  logic [NUM_REGIONS-1:0]        slv_ready,
  output logic                          fault_valid,
  output logic [ADDR_W-1:0]             fault_addr,
  input  logic                          fault_clr
);

  localparam int IW = idx_w(NUM_REGIONS);
  localparam int TW = $clog2(TIMEOUT);

  state_t r_state;
  state_t w_state_next;

  logic                   r_we;
  logic [ADDR_W-1:0]      r_addr;
  logic [ADDR_W-1:0]      r_offset;
  logic [DATA_W-1:0]      r_wdata;
  logic [IW-1:0]          r_idx;
  logic [NUM_REGIONS-1:0] r_sel;
  logic [TW-1:0]          r_timer;
  logic                   r_err;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_fault_valid;
  logic [ADDR_W-1:0]      r_fault_addr;

  logic [NUM_REGIONS-1:0] w_hit;
  logic                   w_found;
  logic [IW-1:0]          w_idx;
  logic [ADDR_W-1:0]      w_offset;
  logic                   w_sel_ready;
  logic [DATA_W-1:0]      w_sel_rdata;
  logic                   w_accept;
  logic                   w_miss;
  logic                   w_ack;
  logic                   w_timeout;
  logic                   w_fault;
  logic [ADDR_W-1:0]      w_fault_addr;

  mmio_region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .REGION_BASE (REGION_BASE),
    .REGION_LOG2 (REGION_LOG2)
  ) u_match (
    .i_addr   (cpu_addr),
    .o_hit    (w_hit),
    .o_found  (w_found),
    .o_idx    (w_idx),
    .o_offset (w_offset)
  );

  // Only the latched slave's ready/data are ever looked at.
  assign w_sel_ready = slv_ready[r_idx];
  assign w_sel_rdata = slv_rdata[int'(r_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_miss       = 1'b0;
    w_ack        = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_req) begin
          if (w_found) begin
            w_state_next = ACCESS;
            w_accept     = 1'b1;
          end else begin
            w_state_next = RESP;
            w_miss       = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (w_sel_ready) begin
          w_state_next = RESP;
          w_ack        = 1'b1;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_state_next = RESP;
          w_timeout    = 1'b1;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_fault      = w_miss | w_timeout;
  assign w_fault_addr = w_miss ? cpu_addr : r_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_offset      <= '0;
      r_wdata       <= '0;
      r_idx         <= '0;
      r_sel         <= '0;
      r_timer       <= '0;
      r_err         <= 1'b0;
      r_rdata       <= '0;
      r_fault_valid <= 1'b0;
      r_fault_addr  <= '0;
    end else begin
      if (w_accept) begin
        r_we     <= cpu_we;
        r_addr   <= cpu_addr;
        r_offset <= w_offset;
        r_wdata  <= cpu_wdata;
        r_idx    <= w_idx;
        r_sel    <= w_hit;
        r_timer  <= '0;
      end else if (r_state == ACCESS) begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_fault) begin
        r_err   <= 1'b1;
        r_rdata <= ERR_DATA;
      end else if (w_ack) begin
        r_err <= 1'b0;
        if (!r_we) r_rdata <= w_sel_rdata;
      end

      // A new fault beats a simultaneous clear so it is never lost.
      if (w_fault && (!r_fault_valid || fault_clr)) begin
        r_fault_valid <= 1'b1;
        r_fault_addr  <= w_fault_addr;
      end else if (fault_clr) begin
        r_fault_valid <= 1'b0;
      end
    end
  end

  assign cpu_busy    = (r_state != IDLE);
  assign cpu_done    = (r_state == RESP);
  assign cpu_err     = (r_state == RESP) & r_err;
  assign cpu_rdata   = r_rdata;
  assign slv_sel     = (r_state == ACCESS) ? r_sel : '0;
  assign slv_we      = (r_state == ACCESS) & r_we;
  assign slv_addr    = r_offset;
  assign slv_wdata   = r_wdata;
  assign fault_valid = r_fault_valid;
  assign fault_addr  = r_fault_addr;

endmodule
